// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the sequential FIR MAC controller.
//   - fir_state_e : controller state encoding (IDLE / MAC / DRAIN / OUT)
//   - addr_w()    : coefficient address width, $clog2(LENGTH)+1
//   - acc_w()     : full-precision accumulator width, 2*WIDTH+$clog2(LENGTH)
//   - sat_s()     : clip a signed value into a WIDTH-bit two's complement range
// Optional feature macro used by the consumers of this package: FIR_ROUND_SAT_EN.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } fir_state_e;

    function automatic int addr_w(input int len);
        return $clog2(len) + 1;
    endfunction

    function automatic int acc_w(input int w, input int len);
        return 2 * w + $clog2(len);
    endfunction

    // Works on a 64-bit carrier so callers of any width up to 64 can share it.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// fir_sample_ring: LENGTH x WIDTH circular sample history.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset; clears history and pointer
//   wr_en_i    in   write wr_data_i at the write pointer, then advance it
//   wr_data_i  in   sample to store
//   rd_off_i   in   read offset back from the newest sample (0 = newest)
//   rd_data_o  out  registered read of history[newest - rd_off_i]
module fir_sample_ring
    import fir_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 16,
    localparam int PW    = $clog2(LENGTH),
    localparam int AW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_off_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [LENGTH-1:0][WIDTH-1:0] hist_q;
    logic [PW-1:0]                wr_ptr_q;
    logic [AW-1:0]                rd_ext;
    logic [PW-1:0]                rd_sel;

    // wr_ptr_q points one past the newest entry. Biasing by LENGTH-1 keeps the
    // subtraction non-negative; one conditional subtract folds it back into range,
    // so non-power-of-two lengths work without a modulo.
    always_comb begin
        rd_ext = {1'b0, wr_ptr_q} + AW'(LENGTH - 1) - rd_off_i;
        rd_sel = PW'((rd_ext >= AW'(LENGTH)) ? (rd_ext - AW'(LENGTH)) : rd_ext);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q    <= '0;
            wr_ptr_q  <= '0;
            rd_data_o <= '0;
        end else begin
            if (wr_en_i) begin
                hist_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q         <= (wr_ptr_q == PW'(LENGTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            rd_data_o <= hist_q[rd_sel];
        end
    end

endmodule

// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: sequential FIR filter controller/datapath.
// Accepts one sample per handshake, walks coefficient addresses 0..LENGTH-1 into
// an external 1-cycle-latency coefficient memory and multiply-accumulates each
// coefficient against the aligned history sample.
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   in_data     in   signed input sample (WIDTH)
//   in_valid    in   in_data valid
//   in_ready    out  block can accept a sample (IDLE only)
//   coeff_addr  out  coefficient address, $clog2(LENGTH)+1 bits, MSB always 0
//   coeff_data  in   signed coefficient, returned one cycle after coeff_addr
//   out_data    out  signed result: ACC_W bits, or WIDTH bits with FIR_ROUND_SAT_EN
//   out_valid   out  out_data valid
//   out_ready   in   downstream accepts out_data
// Macro FIR_ROUND_SAT_EN: round half up, arithmetic shift by SHIFT and saturate
// to WIDTH bits in the DRAIN cycle. Undefined: exact full-precision sum.
module fir_mac_ctrl
    import fir_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LENGTH  = 16,
    parameter int SHIFT   = WIDTH - 1,
    localparam int ACC_W  = acc_w(WIDTH, LENGTH),
    localparam int ADDR_W = addr_w(LENGTH),
`ifdef FIR_ROUND_SAT_EN
    localparam int OUT_W  = WIDTH
`else
    localparam int OUT_W  = ACC_W
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ADDR_W-1:0]       coeff_addr,
    input  logic signed [WIDTH-1:0] coeff_data,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(LENGTH - 1);

    if (LENGTH < 2 || SHIFT < 0) begin : g_bad_cfg
        $error("fir_mac_ctrl: LENGTH must be >= 2 and SHIFT >= 0");
    end

    fir_state_e               state_q, state_d;
    logic [ADDR_W-1:0]        k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [OUT_W-1:0]  out_q, out_d;
    logic [WIDTH-1:0]         smp;
    logic                     ring_we;
    logic signed [ACC_W-1:0]  smp_ext, cf_ext, prod, acc_sum;
    logic signed [OUT_W-1:0]  result;

    fir_sample_ring #(
        .WIDTH (WIDTH),
        .LENGTH(LENGTH)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (ring_we),
        .wr_data_i(in_data),
        .rd_off_i (k_q),
        .rd_data_o(smp)
    );

    // smp and coeff_data both trail coeff_addr by one cycle, so they always
    // belong to the same tap k-1 when seen in cycle k.
    always_comb begin
        smp_ext = ACC_W'($signed(smp));
        cf_ext  = ACC_W'(coeff_data);
        prod    = smp_ext * cf_ext;
        acc_sum = acc_q + prod;
    end

`ifdef FIR_ROUND_SAT_EN
    localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'((2 ** SHIFT) / 2);
    logic signed [ACC_W:0] rnd_sum, rnd_shr;
    logic signed [63:0]    rnd_sat;

    // One guard bit so the rounding add can never wrap.
    always_comb begin
        rnd_sum = {acc_sum[ACC_W-1], acc_sum} + RND;
        rnd_shr = rnd_sum >>> SHIFT;
        rnd_sat = sat_s(64'(rnd_shr), WIDTH);
        result  = OUT_W'(rnd_sat);
    end
`else
    always_comb result = acc_sum;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        out_d   = out_q;
        ring_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ring_we = 1'b1;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                // First MAC cycle has no product in flight yet.
                if (k_q != '0) acc_d = acc_sum;
                if (k_q == K_LAST) state_d = DRAIN;
                else               k_d     = k_q + ADDR_W'(1);
            end
            DRAIN: begin
                out_d   = result;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == OUT);
    assign out_data   = out_q;
    assign coeff_addr = k_q;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// tb_fir_mac_ctrl: self-checking bench for fir_mac_ctrl (WIDTH=8, LENGTH=4) with
// a registered-read coefficient memory and a queue-based convolution model.
// Honors FIR_ROUND_SAT_EN in its reference model.
module tb_fir_mac_ctrl;

    localparam int W    = 8;
    localparam int L    = 4;
    localparam int AW   = $clog2(L) + 1;
    localparam int ACCW = 2 * W + $clog2(L);
    localparam int SH   = W - 1;
`ifdef FIR_ROUND_SAT_EN
    localparam int OW = W;
`else
    localparam int OW = ACCW;
`endif

    logic                 clk;
    logic                 rst;
    logic signed [W-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [AW-1:0]        coeff_addr;
    logic signed [W-1:0]  coeff_data;
    logic signed [OW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    fir_mac_ctrl #(.WIDTH(W), .LENGTH(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coeff_addr(coeff_addr),
        .coeff_data(coeff_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [W-1:0] cmem [L];
    always @(posedge clk) coeff_data <= cmem[coeff_addr[AW-2:0]];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    // Reference: history queue with the newest sample first; y = sum c[k]*x[n-k].
    longint hist[$];

    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < L; k++)
            if (k < hist.size()) s += longint'(cmem[k]) * hist[k];
        return s;
    endfunction

    function automatic longint post(input longint v);
`ifdef FIR_ROUND_SAT_EN
        longint r;
        longint hi = (64'sd1 <<< (W - 1)) - 1;
        longint lo = -(64'sd1 <<< (W - 1));
        r = (v + (longint'(2) ** SH) / 2) >>> SH;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
`else
        return v;
`endif
    endfunction

    task automatic push(input int x);
        hist.push_front(longint'(x));
        if (hist.size() > L) void'(hist.pop_back());
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_in_ready",  in_ready,   1);
        chk("rst_out_valid", out_valid,  0);
        chk("rst_out_data",  out_data,   0);
        chk("rst_coeff_addr", coeff_addr, 0);
        hist.delete();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic accept(input int x);
        int t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!in_ready) chk("accept_timeout", 0, 1);
        in_data  = W'(x);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        push(x);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid) chk("out_timeout", 0, 1);
    endtask

    // One sample through the filter; stall>0 holds out_ready low that many cycles in OUT.
    task automatic xfer(input int x, input int stall, output longint y);
        int     lat;
        longint e;
        out_ready = (stall == 0);
        accept(x);
        e = post(model_y());
        wait_out(lat);
        chk("latency", lat, L + 1);
        y = out_data;
        chk("out_data", y, e);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data",  out_data,  y);
            chk("bp_ready", in_ready,  0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid", out_valid, 0);
        chk("hs_idle",  in_ready,  1);
    endtask

    initial begin : wdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        longint y;
        int     lat;
        int     imp   [5] = '{1, 0, 0, 0, 0};
        int     imp_e [5] = '{1, 2, 3, 4, 0};
        int     stp_e [5] = '{10, 30, 60, 100, 100};
        logic signed [W-1:0] r;

        for (int k = 0; k < L; k++) cmem[k] = W'(k + 1);
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        rst       = 1'b1;
        #3;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            xfer(imp[i], 0, y);
            chk("impulse", y, post(longint'(imp_e[i])));
        end

        for (int i = 0; i < 5; i++) begin
            xfer(10, 0, y);
            chk("step", y, post(longint'(stp_e[i])));
        end

        for (int i = 0; i < 4; i++) xfer(-128, 0, y);
        chk("neg_full", y, post(-1280));

        xfer(7, 10, y);

        // Reset while the MAC walk is at k=2.
        accept(5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mac_k2", coeff_addr, 2);
        do_reset();
        xfer(1, 0, y);
        chk("rst_impulse", y, post(1));

        // Back-to-back with in_valid held high.
        do_reset();
        in_data  = 8'sd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        push(1);
        in_data = 8'sd2;
        wait_out(lat);
        chk("b2b_lat0", lat, L + 1);
        chk("b2b_y0", out_data, post(1));
        @(posedge clk); #1;
        chk("b2b_idle", in_ready, 1);
        @(posedge clk); #1;
        chk("b2b_taken", in_ready, 0);
        in_valid = 1'b0;
        push(2);
        wait_out(lat);
        chk("b2b_lat1", lat, L + 1);
        chk("b2b_y1", out_data, post(4));
        @(posedge clk); #1;
        chk("b2b_hs", out_valid, 0);

        // Randomized samples, coefficients and backpressure.
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int k = 0; k < L; k++) cmem[k] = W'($urandom);
            for (int i = 0; i < 20; i++) begin
                r = W'($urandom);
                xfer(int'(r), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, y);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
